if_prefetch_queue: RTL and testbench

//   Instruction prefetch queue in front of the if_id pipeline register. Runs ahead of the
//   IF stage using a req/ack instruction-memory port and buffers {pc,instr} pairs in a FIFO.

---
 rtl/if_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// ============================================================================
// Module  : if_prefetch_queue
// Brief   : Instruction prefetch FIFO that fetches {pc,instr} ahead of IF via
//           req/ack memory port. Optional perf counters: PREFETCH_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        pause,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
`ifdef PREFETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt,
`endif
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fpc;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [31:0]        w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign w_push        = (r_state == S_WAIT) && mem_ack && !redirect;
  assign w_pop         = out_valid && !pause && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fpc      <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!redirect && !w_full) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fpc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
            if (!redirect) begin
              r_fpc <= r_fpc + 32'd4;
            end
          end else if (redirect) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          // Stale request stays on the bus until memory answers it.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase

      if (redirect) begin
        r_fpc    <= w_redirect_pc;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_mem_addr;
      r_instr_mem[r_wr_ptr] <= mem_rdata;
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= 32'h0;
      r_perf_drop  <= 32'h0;
    end else begin
      if (w_push) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (mem_ack && ((r_state == S_DROP) || ((r_state == S_WAIT) && redirect))) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`endif

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// Module  : tb_if_prefetch_queue
// Brief   : Scoreboard bench for if_prefetch_queue with a latency-controlled
//           memory responder and a consumer that pops expected {pc,instr}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        pause = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 0;
  bit          resp_en = 1'b0;
  int          n_ack   = 0;
  logic [31:0] exp_q    [$];
  logic [31:0] addr_log [$];

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pause       (pause),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
`ifdef PREFETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks 'lat' cycles after seeing a request, data = img(addr).
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wcnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = img(mem_addr);
            wcnt      = 0;
            n_ack++;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Request-address log and consumer side of the scoreboard.
  initial begin
    logic prev_req;
    logic [31:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) addr_log.push_back(mem_addr);
      prev_req = mem_req;
      if (!rst && out_valid && !pause && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_instr", out_instr, img(e));
      end
    end
  end

  task automatic do_reset(input bit p);
    rst      = 1'b1;
    pause    = p;
    redirect = 1'b0;
    if (!resp_en) mem_ack = 1'b0;
    tick();
    tick();
    exp_q.delete();
    addr_log.delete();
    n_ack = 0;
    if (!resp_en) mem_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    @(negedge clk);
    for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
    chk(tag, {31'b0, mem_req}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state and free-running fetch with 1-cycle ack.
    resp_en = 1'b1;
    lat     = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    tick();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    wait_drain("drain_seq");

    // Pause held: queue fills to DEPTH, then drains in order.
    do_reset(1'b1);
    repeat (30) @(negedge clk);
    chk("full_pushes", n_ack, 32'd4);
    chk("full_mem_req", {31'b0, mem_req}, 32'd0);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_out_pc", out_pc, 32'h0);
    chk("full_out_instr", out_instr, img(32'h0));
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    tick();
    pause = 1'b0;
    wait_drain("drain_full");

    // Redirect while waiting: stale ack dropped, restart at 0x100.
    lat = 3;
    do_reset(1'b0);
    wait_req("t3_req");
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    @(negedge clk);
    chk("drop_req_held", {31'b0, mem_req}, 32'd1);
    chk("drop_addr_held", mem_addr, 32'h0);
    chk("drop_no_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 50 && addr_log.size() < 2; i++) @(negedge clk);
    chk("redir_log_len", addr_log.size(), 32'd2);
    if (addr_log.size() >= 2) chk("redir_addr", addr_log[1], 32'h100);
    wait_drain("drain_redir");
`ifdef PREFETCH_PERF_EN
    chk("perf_drop", perf_drop_cnt, 32'd1);
`endif

    // Redirect and ack in the same cycle: no push, refetch from target.
    resp_en = 1'b0;
    lat     = 0;
    do_reset(1'b0);
    wait_req("t4_req");
    tick();
    mem_ack     = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("ackredir_valid", {31'b0, out_valid}, 32'd0);
    chk("ackredir_req", {31'b0, mem_req}, 32'd0);
`ifdef PREFETCH_PERF_EN
    chk("perf_drop2", perf_drop_cnt, 32'd1);
    chk("perf_fetch2", perf_fetch_cnt, 32'd0);
`endif
    @(negedge clk);
    chk("ackredir_req2", {31'b0, mem_req}, 32'd1);
    chk("ackredir_addr", mem_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    resp_en = 1'b1;
    wait_drain("drain_ackredir");

    // count==1 with push and pop on the same edge.
    resp_en = 1'b0;
    do_reset(1'b1);
    wait_req("t5_req0");
    tick();
    mem_ack   = 1'b1;
    mem_rdata = img(32'h0);
    tick();
    mem_ack = 1'b0;
    wait_req("t5_req1");
    chk("t5_addr1", mem_addr, 32'h4);
    exp_q.push_back(32'h0);
    tick();
    pause     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = img(32'h4);
    tick();
    pause   = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("pp_valid", {31'b0, out_valid}, 32'd1);
    chk("pp_out_pc", out_pc, 32'h4);
    chk("pp_out_instr", out_instr, img(32'h4));
    chk("pp_consumed", exp_q.size(), 32'd0);

    // Reset mid-request: outputs clear, late ack ignored.
    do_reset(1'b1);
    wait_req("t6_req0");
    tick();
    mem_ack   = 1'b1;
    mem_rdata = img(32'h0);
    tick();
    mem_ack = 1'b0;
    wait_req("t6_req1");
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("mrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("mrst_mem_addr", mem_addr, 32'h0);
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_out_pc", out_pc, 32'h0);
    chk("mrst_out_instr", out_instr, 32'h0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", {31'b0, out_valid}, 32'd0);
    chk("late_req", {31'b0, mem_req}, 32'd1);
    chk("late_addr", mem_addr, 32'h0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = img(32'h0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_pc", out_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
